shift_register: RTL and testbench

- Parameterisable serial-in, parallel-out bidirectional shift register with a shift enable.
- One serial bit enters per enabled clock edge. The direction input selects which end it enters, and the full register contents are exposed in parallel.
- Used as a small datapath/test utility block: serial-to-parallel conversion, pattern capture, and simple bit-stream alignment.

---
 rtl/shift_register.sv | 31 +++
 tb/tb_shift_register.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// Serial-in, parallel-out bidirectional shift register with shift enable.
// One bit enters per enabled rising edge. dir = 0 feeds bit 0 and moves data
// toward the MSB. dir = 1 feeds bit WIDTH-1 and moves data toward the LSB.
// The whole register is visible on sreg, driven straight from flops.
module shift_register #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             data_in,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] sreg
);

  // Asynchronous clear, otherwise shift in the selected direction when enabled.
  // data_in and dir are only sampled under en, so an X on them while holding
  // never reaches the register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sreg <= '0;
    end else if (en) begin
      if (dir) begin
        sreg <= {data_in, sreg[WIDTH-1:1]};
      end else begin
        sreg <= {sreg[WIDTH-2:0], data_in};
      end
    end
  end

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register (WIDTH = 5 and WIDTH = 8 instances).
// Every driven edge pushes the model's expected contents to a queue; each
// scenario task pops the expected value after the edge and compares it.
module tb_shift_register;

  logic       clk = 1'b0;
  logic       nrst, data_in, en, dir;
  logic [4:0] sreg;
  logic       nrst8, data_in8, en8, dir8;
  logic [7:0] sreg8;

  int checks = 0;
  int errors = 0;

  logic [4:0] model;
  logic [7:0] model8;
  logic [4:0] exp_q[$];
  logic [7:0] exp8_q[$];
  logic [4:0] expv;
  logic [7:0] expv8;

  shift_register #(.WIDTH(5)) dut (
    .clk(clk), .nrst(nrst), .data_in(data_in), .en(en), .dir(dir), .sreg(sreg)
  );

  shift_register #(.WIDTH(8)) dut8 (
    .clk(clk), .nrst(nrst8), .data_in(data_in8), .en(en8), .dir(dir8), .sreg(sreg8)
  );

  always #5 clk = ~clk;

  // Drive one edge on the 5-bit instance and queue the expected result.
  task automatic step(input logic e, input logic d_dir, input logic d);
    en = e; dir = d_dir; data_in = d;
    if (e === 1'b1) model = d_dir ? {d, model[4:1]} : {model[3:0], d};
    exp_q.push_back(model);
    @(posedge clk); #1;
  endtask

  // Drive one edge on the 8-bit instance and queue the expected result.
  task automatic step8(input logic e, input logic d_dir, input logic d);
    en8 = e; dir8 = d_dir; data_in8 = d;
    if (e === 1'b1) model8 = d_dir ? {d, model8[7:1]} : {model8[6:0], d};
    exp8_q.push_back(model8);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    nrst = 1'b0; nrst8 = 1'b0;
    en = 1'b1; data_in = 1'b1; dir = 1'b0;
    en8 = 1'b0; data_in8 = 1'b0; dir8 = 1'b0;
    model = '0; model8 = '0;
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sreg !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL reset_hold[%0d] got %b expected 00000", i, sreg);
      end
      #5;
    end
    // Released at t=17, between edges, with shifting disabled.
    en = 1'b0;
    nrst = 1'b1; nrst8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1);
      expv = exp_q.pop_front();
      checks++;
      if (sreg !== expv || sreg !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL reset_release[%0d] got %b expected %b", i, sreg, expv);
      end
    end
  endtask

  task automatic test_left_fill;
    logic [4:0] plan [0:6];
    plan = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11111, 5'b11111};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b1);
      expv = exp_q.pop_front();
      checks++;
      if (sreg !== expv || sreg !== plan[i]) begin
        errors++;
        $display("[TB] FAIL left_fill[%0d] got %b expected %b", i, sreg, plan[i]);
      end
    end
  endtask

  task automatic test_right_flush;
    logic [4:0] plan [0:4];
    plan = '{5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      expv = exp_q.pop_front();
      checks++;
      if (sreg !== expv || sreg !== plan[i]) begin
        errors++;
        $display("[TB] FAIL right_flush[%0d] got %b expected %b", i, sreg, plan[i]);
      end
    end
  endtask

  task automatic test_hold;
    logic [4:0] load_bits;
    load_bits = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      step(1'b1, 1'b0, load_bits[i]);
      expv = exp_q.pop_front();
      checks++;
      if (sreg !== expv) begin
        errors++;
        $display("[TB] FAIL hold_load[%0d] got %b expected %b", i, sreg, expv);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0], (i == 2) ? 1'bx : ~i[0]);
      expv = exp_q.pop_front();
      checks++;
      if (sreg !== expv || sreg !== 5'b10110) begin
        errors++;
        $display("[TB] FAIL hold[%0d] got %b expected 10110", i, sreg);
      end
    end
    step(1'b1, 1'b1, 1'b1);
    expv = exp_q.pop_front();
    checks++;
    if (sreg !== expv || sreg !== 5'b11011) begin
      errors++;
      $display("[TB] FAIL hold_resume got %b expected 11011", sreg);
    end
  endtask

  task automatic test_dir_reversal;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      void'(exp_q.pop_front());
    end
    checks++;
    if (sreg !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL rev_clear got %b expected 00000", sreg);
    end
    step(1'b1, 1'b0, 1'b1); void'(exp_q.pop_front());
    step(1'b1, 1'b0, 1'b0); void'(exp_q.pop_front());
    step(1'b1, 1'b0, 1'b1);
    expv = exp_q.pop_front();
    checks++;
    if (sreg !== expv || sreg !== 5'b00101) begin
      errors++;
      $display("[TB] FAIL rev_left got %b expected 00101", sreg);
    end
    step(1'b1, 1'b1, 1'b0);
    expv = exp_q.pop_front();
    checks++;
    if (sreg !== expv || sreg !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL rev_right got %b expected 00010", sreg);
    end
  endtask

  task automatic test_back_to_back;
    logic e, dd, d;
    for (int i = 0; i < 40; i++) begin
      e = 1'($urandom_range(0, 3) != 0);
      dd = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      step(e, dd, d);
      expv = exp_q.pop_front();
      checks++;
      if (sreg !== expv) begin
        errors++;
        $display("[TB] FAIL b2b[%0d] got %b expected %b", i, sreg, expv);
      end
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      void'(exp_q.pop_front());
    end
    checks++;
    if (sreg !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL async_pre got %b expected 11111", sreg);
    end
    #3 nrst = 1'b0;
    #1;
    model = '0;
    checks++;
    if (sreg !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL async_clear got %b expected 00000", sreg);
    end
    #2 nrst = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    expv = exp_q.pop_front();
    checks++;
    if (sreg !== expv || sreg !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL async_resume got %b expected 00001", sreg);
    end
  endtask

  task automatic test_width8;
    for (int i = 0; i < 9; i++) begin
      step8(1'b1, 1'b0, 1'b1);
      expv8 = exp8_q.pop_front();
      checks++;
      if (sreg8 !== expv8) begin
        errors++;
        $display("[TB] FAIL w8_fill[%0d] got %b expected %b", i, sreg8, expv8);
      end
      if (i == 7) begin
        checks++;
        if (sreg8 !== 8'hFF) begin
          errors++;
          $display("[TB] FAIL w8_full got %b expected 11111111", sreg8);
        end
      end
    end
    step8(1'b1, 1'b1, 1'b0);
    expv8 = exp8_q.pop_front();
    checks++;
    if (sreg8 !== expv8 || sreg8 !== 8'b01111111) begin
      errors++;
      $display("[TB] FAIL w8_right got %b expected 01111111", sreg8);
    end
  endtask

  initial begin
    test_reset();
    test_left_fill();
    test_right_flush();
    test_hold();
    test_dir_reversal();
    test_back_to_back();
    test_async_reset();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
